// File: rtl/axis_motion_ctrl.sv
// ============================================================================
//  Module   : axis_motion_ctrl
//  Purpose  : N-axis position controller. Each axis steps toward a captured
//             target, either all together or one axis at a time.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module axis_motion_ctrl #(
  parameter int NAXES = 2,
  parameter int WIDTH = 4,
  parameter int DIV_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NAXES*WIDTH-1:0] target,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   home,
  input  logic                   mode,
  input  logic [DIV_W-1:0]       step_div,
  output logic [NAXES*WIDTH-1:0] pos,
  output logic [NAXES-1:0]       axis_dir,
  output logic [NAXES-1:0]       axis_step,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MOVE = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                         r_state;
  state_t                         w_next_state;
  logic [NAXES-1:0][WIDTH-1:0]    r_pos;
  logic [NAXES-1:0][WIDTH-1:0]    r_treg;
  logic [DIV_W-1:0]               r_div;
  logic [DIV_W-1:0]               r_presc;
  logic                           r_mode;
  logic                           r_start_q;

  logic                           w_start_edge;
  logic [NAXES-1:0]               w_neq;
  logic [NAXES-1:0]               w_up;
  logic [NAXES-1:0]               w_first;
  logic [NAXES-1:0]               w_movers;
  logic [NAXES-1:0]               w_step;
  logic                           w_all_eq;
  logic                           w_in_move;
  logic                           w_tick;

  assign w_start_edge = start & ~r_start_q;

  for (genvar i = 0; i < NAXES; i++) begin : g_axis
    assign w_neq[i] = (r_pos[i] != r_treg[i]);
    assign w_up[i]  = (r_pos[i] <  r_treg[i]);
  end

  assign w_all_eq = ~|w_neq;
  // Isolate the lowest-index axis still away from its target.
  assign w_first  = w_neq & (~w_neq + NAXES'(1));
  assign w_movers = r_mode ? w_first : w_neq;

  assign w_in_move = (r_state == ST_MOVE) & ~reset;
  assign w_tick    = w_in_move & ~abort & ~w_all_eq & (r_presc == r_div);
  assign w_step    = w_tick ? w_movers : '0;

  assign pos       = r_pos;
  assign axis_step = w_step;
  assign axis_dir  = w_in_move ? (w_movers & w_up) : '0;
  assign busy      = (r_state == ST_MOVE);
  assign done      = (r_state == ST_DONE);

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (!home && w_start_edge) w_next_state = ST_MOVE;
      ST_MOVE: begin
        if (abort)         w_next_state = ST_IDLE;
        else if (w_all_eq) w_next_state = ST_DONE;
      end
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pos     <= '0;
      r_treg    <= '0;
      r_div     <= '0;
      r_presc   <= '0;
      r_mode    <= 1'b0;
      r_start_q <= 1'b0;
    end else begin
      r_start_q <= start;
      case (r_state)
        ST_IDLE: begin
          if (home) begin
            r_pos  <= '0;
            r_treg <= '0;
          end else if (w_start_edge) begin
            r_treg  <= target;
            r_div   <= step_div;
            r_mode  <= mode;
            r_presc <= '0;
          end
        end
        ST_MOVE: begin
          if (!abort && !w_all_eq) begin
            if (r_presc == r_div) begin
              r_presc <= '0;
              for (int i = 0; i < NAXES; i++) begin
                if (w_step[i])
                  r_pos[i] <= w_up[i] ? r_pos[i] + WIDTH'(1) : r_pos[i] - WIDTH'(1);
              end
            end else begin
              r_presc <= r_presc + DIV_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axis_motion_ctrl.sv
// ============================================================================
//  Module   : tb_axis_motion_ctrl
//  Purpose  : Directed vector bench for axis_motion_ctrl (NAXES=2, WIDTH=4).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_axis_motion_ctrl;

  logic       clk;
  logic       reset;
  logic [7:0] target;
  logic       start;
  logic       abort;
  logic       home;
  logic       mode;
  logic [7:0] step_div;
  logic [7:0] pos;
  logic [1:0] axis_dir;
  logic [1:0] axis_step;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  axis_motion_ctrl #(.NAXES(2), .WIDTH(4), .DIV_W(8)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .target    (target),
    .start     (start),
    .abort     (abort),
    .home      (home),
    .mode      (mode),
    .step_div  (step_div),
    .pos       (pos),
    .axis_dir  (axis_dir),
    .axis_step (axis_step),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] tgt;
    logic       st, ab, hm, md;
    logic [7:0] dv;
    logic [7:0] e_pos;
    logic [1:0] e_dir, e_step;
    logic       e_busy, e_done;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(logic [7:0] tgt, logic st, logic ab, logic hm, logic md,
                             logic [7:0] dv, logic [7:0] e_pos, logic [1:0] e_dir,
                             logic [1:0] e_step, logic e_busy, logic e_done);
    vec_t r;
    r.tgt = tgt; r.st = st; r.ab = ab; r.hm = hm; r.md = md; r.dv = dv;
    r.e_pos = e_pos; r.e_dir = e_dir; r.e_step = e_step;
    r.e_busy = e_busy; r.e_done = e_done;
    return r;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %0h expected %0h at %0t", nm, idx, act, exp, $time);
    end
  endtask

  // Inputs change at the falling edge; outputs are sampled 1ns later.
  task automatic apply(input logic [7:0] t, input logic s, input logic a, input logic h,
                       input logic m, input logic [7:0] d);
    @(negedge clk);
    target = t; start = s; abort = a; home = h; mode = m; step_div = d;
    #1;
  endtask

  task automatic hold();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input int bound, output int xsteps);
    bit seen;
    seen   = 1'b0;
    xsteps = 0;
    for (int k = 0; k < bound && !seen; k++) begin
      hold();
      if (axis_step[0]) xsteps++;
      if (done) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL wait_done: done not seen within %0d cycles", bound);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

  initial begin
    int xs;

    // Simultaneous move (0,0)->(3,5), step_div=0
    vecs.push_back(v(8'h53,1,0,0,0,8'd0, 8'h00,2'b00,2'b00,0,0));
    vecs.push_back(v(8'h53,1,0,0,0,8'd0, 8'h00,2'b11,2'b11,1,0));
    vecs.push_back(v(8'h53,1,0,0,0,8'd0, 8'h11,2'b11,2'b11,1,0));
    vecs.push_back(v(8'h53,1,0,0,0,8'd0, 8'h22,2'b11,2'b11,1,0));
    vecs.push_back(v(8'h53,1,0,0,0,8'd0, 8'h33,2'b10,2'b10,1,0));
    vecs.push_back(v(8'h53,1,0,0,0,8'd0, 8'h43,2'b10,2'b10,1,0));
    vecs.push_back(v(8'h53,1,0,0,0,8'd0, 8'h53,2'b00,2'b00,1,0));
    vecs.push_back(v(8'h53,1,0,0,0,8'd0, 8'h53,2'b00,2'b00,0,1));
    vecs.push_back(v(8'h53,1,0,0,0,8'd0, 8'h53,2'b00,2'b00,0,0));
    // Home in IDLE
    vecs.push_back(v(8'h53,0,0,1,0,8'd0, 8'h53,2'b00,2'b00,0,0));
    vecs.push_back(v(8'h53,0,0,0,0,8'd0, 8'h00,2'b00,2'b00,0,0));
    // Sequential move; target/mode/div changes and start toggle mid-move ignored
    vecs.push_back(v(8'h53,1,0,0,1,8'd0, 8'h00,2'b00,2'b00,0,0));
    vecs.push_back(v(8'h53,0,0,0,1,8'd0, 8'h00,2'b01,2'b01,1,0));
    vecs.push_back(v(8'hFF,1,0,0,1,8'd0, 8'h01,2'b01,2'b01,1,0));
    vecs.push_back(v(8'hFF,0,0,0,0,8'd7, 8'h02,2'b01,2'b01,1,0));
    vecs.push_back(v(8'hFF,0,0,0,0,8'd7, 8'h03,2'b10,2'b10,1,0));
    vecs.push_back(v(8'hFF,0,0,0,0,8'd7, 8'h13,2'b10,2'b10,1,0));
    vecs.push_back(v(8'hFF,0,0,0,0,8'd7, 8'h23,2'b10,2'b10,1,0));
    vecs.push_back(v(8'hFF,0,0,0,0,8'd7, 8'h33,2'b10,2'b10,1,0));
    vecs.push_back(v(8'hFF,0,0,0,0,8'd7, 8'h43,2'b10,2'b10,1,0));
    vecs.push_back(v(8'hFF,0,0,0,0,8'd7, 8'h53,2'b00,2'b00,1,0));
    vecs.push_back(v(8'hFF,0,0,0,0,8'd7, 8'h53,2'b00,2'b00,0,1));
    vecs.push_back(v(8'hFF,0,0,0,0,8'd7, 8'h53,2'b00,2'b00,0,0));
    // Home, then step_div=3 toward (1,0)
    vecs.push_back(v(8'h00,0,0,1,0,8'd0, 8'h53,2'b00,2'b00,0,0));
    vecs.push_back(v(8'h01,1,0,0,0,8'd3, 8'h00,2'b00,2'b00,0,0));
    vecs.push_back(v(8'h01,1,0,0,0,8'd3, 8'h00,2'b01,2'b00,1,0));
    vecs.push_back(v(8'h01,1,0,0,0,8'd3, 8'h00,2'b01,2'b00,1,0));
    vecs.push_back(v(8'h01,1,0,0,0,8'd3, 8'h00,2'b01,2'b00,1,0));
    vecs.push_back(v(8'h01,1,0,0,0,8'd3, 8'h00,2'b01,2'b01,1,0));
    vecs.push_back(v(8'h01,1,0,0,0,8'd3, 8'h01,2'b00,2'b00,1,0));
    vecs.push_back(v(8'h01,1,0,0,0,8'd3, 8'h01,2'b00,2'b00,0,1));
    vecs.push_back(v(8'h01,0,0,0,0,8'd3, 8'h01,2'b00,2'b00,0,0));

    reset = 1'b1; target = '0; start = 0; abort = 0; home = 0; mode = 0; step_div = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_pos", 0, pos, 8'h00);
    chk("rst_busy", 0, busy, 1'b0);
    chk("rst_done", 0, done, 1'b0);
    chk("rst_step", 0, axis_step, 2'b00);
    chk("rst_dir", 0, axis_dir, 2'b00);

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].tgt, vecs[i].st, vecs[i].ab, vecs[i].hm, vecs[i].md, vecs[i].dv);
      chk("pos",  i, pos,       vecs[i].e_pos);
      chk("dir",  i, axis_dir,  vecs[i].e_dir);
      chk("step", i, axis_step, vecs[i].e_step);
      chk("busy", i, busy,      vecs[i].e_busy);
      chk("done", i, done,      vecs[i].e_done);
    end

    // Move to (3,5), then count X down to 0 with step_div=3
    apply(8'h53, 1, 0, 0, 0, 8'd0);
    wait_done(20, xs);
    chk("to53_pos", 0, pos, 8'h53);
    apply(8'h50, 0, 0, 0, 0, 8'd3);
    apply(8'h50, 1, 0, 0, 0, 8'd3);
    hold();
    chk("down_dir", 0, axis_dir, 2'b00);
    chk("down_busy", 0, busy, 1'b1);
    wait_done(40, xs);
    chk("down_xsteps", 0, xs, 3);
    chk("down_pos", 0, pos, 8'h50);

    // Abort at (2,2) on the way to (9,9)
    apply(8'h50, 0, 0, 0, 0, 8'd0);
    apply(8'h50, 0, 0, 1, 0, 8'd0);
    apply(8'h50, 0, 0, 0, 0, 8'd0);
    chk("home_pos", 1, pos, 8'h00);
    apply(8'h99, 1, 0, 0, 0, 8'd0);
    hold();
    chk("ab_step1", 0, axis_step, 2'b11);
    hold();
    chk("ab_pos1", 0, pos, 8'h11);
    apply(8'h99, 1, 1, 0, 0, 8'd0);
    chk("ab_pos2", 0, pos, 8'h22);
    chk("ab_step", 0, axis_step, 2'b00);
    chk("ab_busy", 0, busy, 1'b1);
    apply(8'h99, 1, 0, 0, 0, 8'd0);
    chk("ab_idle_busy", 0, busy, 1'b0);
    chk("ab_idle_done", 0, done, 1'b0);
    chk("ab_hold_pos", 0, pos, 8'h22);
    hold();
    chk("ab_hold_pos", 1, pos, 8'h22);
    chk("ab_nodone", 1, done, 1'b0);
    apply(8'h40, 0, 0, 0, 0, 8'd0);
    apply(8'h40, 1, 0, 0, 0, 8'd0);
    wait_done(20, xs);
    chk("resume_pos", 0, pos, 8'h40);
    chk("resume_xsteps", 0, xs, 2);

    // Target equal to current position
    apply(8'h40, 0, 0, 0, 0, 8'd0);
    apply(8'h40, 1, 0, 0, 0, 8'd0);
    hold();
    chk("eq_busy", 0, busy, 1'b1);
    chk("eq_step", 0, axis_step, 2'b00);
    hold();
    chk("eq_done", 0, done, 1'b1);
    chk("eq_pos", 0, pos, 8'h40);

    // home and start edge in the same cycle: home wins
    apply(8'h77, 0, 0, 0, 0, 8'd0);
    apply(8'h77, 1, 0, 1, 0, 8'd0);
    apply(8'h77, 1, 0, 0, 0, 8'd0);
    chk("hs_pos", 0, pos, 8'h00);
    chk("hs_busy", 0, busy, 1'b0);
    hold();
    chk("hs_busy", 1, busy, 1'b0);
    chk("hs_pos", 1, pos, 8'h00);

    // Reset during MOVE
    apply(8'hFF, 0, 0, 0, 0, 8'd0);
    apply(8'hFF, 1, 0, 0, 0, 8'd0);
    hold();
    hold();
    hold();
    chk("prerst_pos", 0, pos, 8'h22);
    @(negedge clk);
    reset = 1'b1; start = 1'b0;
    #1;
    chk("rst_mv_step", 0, axis_step, 2'b00);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_mv_pos", 0, pos, 8'h00);
    chk("rst_mv_busy", 0, busy, 1'b0);
    chk("rst_mv_done", 0, done, 1'b0);
    for (int k = 0; k < 3; k++) begin
      hold();
      chk("rst_mv_nodone", k, done, 1'b0);
      chk("rst_mv_idle", k, busy, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
